// File: rtl/sonar_pkg.sv
// Shared state encoding, angle type and default timing for the sonar ping datapath.
package sonar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        LISTEN = 2'd2
    } ping_state_e;

    localparam int DEF_PERIOD_CYCLES = 32'sd16777216;
    localparam int DEF_BURST_CYCLES  = 32'sd524288;
    localparam int DEF_BLANK_CYCLES  = 32'sd65536;
    localparam int DEF_SAMPLE_CYCLES = 32'sd100;
    localparam int DEF_ANGLE_WIDTH   = 32'sd8;
    localparam int DEF_ANGLE_MIN     = -32'sd30;
    localparam int DEF_ANGLE_MAX     = 32'sd30;
    localparam int DEF_ANGLE_STEP    = 32'sd10;
    localparam int DEF_DATA_WIDTH    = 32'sd16;

    typedef logic signed [DEF_ANGLE_WIDTH-1:0] angle_t;

    // Bits needed for a counter over 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/angle_sequencer.sv
// Sweep pointer for the ping sequencer: steps through the angle range, wraps,
// and supplies the angle to latch when a ping starts.
module angle_sequencer
    import sonar_pkg::*;
#(
    parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
    parameter int ANGLE_MIN   = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX   = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP  = DEF_ANGLE_STEP
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          advance_in,
    input  logic                          sweep_mode_in,
    input  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in,
    output logic signed [ANGLE_WIDTH-1:0] start_angle_out,
    output logic                          sweep_done_out
);

    localparam logic signed [ANGLE_WIDTH:0]   MAX_EXT  = (ANGLE_WIDTH+1)'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH:0]   STEP_EXT = (ANGLE_WIDTH+1)'(ANGLE_STEP);
    localparam logic signed [ANGLE_WIDTH-1:0] MIN_ANG  = ANGLE_WIDTH'(ANGLE_MIN);

    logic signed [ANGLE_WIDTH-1:0] ptr_r;
    logic signed [ANGLE_WIDTH-1:0] ptr_next_s;
    logic signed [ANGLE_WIDTH:0]   sum_s;
    logic                          wrap_s;

    // Next pointer, wrap detection and the angle offered to a starting ping.
    always_comb begin
        // One extra bit keeps pointer + step from overflowing near the type limit.
        sum_s  = (ANGLE_WIDTH+1)'(ptr_r) + STEP_EXT;
        wrap_s = (sum_s > MAX_EXT);
        if (!advance_in) begin
            ptr_next_s = ptr_r;
        end else if (wrap_s) begin
            ptr_next_s = MIN_ANG;
        end else begin
            ptr_next_s = sum_s[ANGLE_WIDTH-1:0];
        end
        if (sweep_mode_in) begin
            start_angle_out = ptr_next_s;
        end else begin
            start_angle_out = fixed_angle_in;
        end
        sweep_done_out = advance_in && wrap_s;
    end

    // Sweep pointer register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_r <= MIN_ANG;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

endmodule

// File: rtl/sweep_ping_controller.sv
// Ping sequencer: burst/listen scheduling, ADC sample triggers, first-echo
// detection after blanking, and one registered range/angle result per ping.
module sweep_ping_controller
    import sonar_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int BURST_CYCLES  = DEF_BURST_CYCLES,
    parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
    parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int T_WIDTH       = $clog2(PERIOD_CYCLES)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic                          sweep_mode_in,
    input  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in,
    input  logic [DATA_WIDTH-1:0]         threshold_in,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic                          sample_valid_in,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                          burst_active_out,
    output logic                          burst_start_out,
    output logic                          sample_trigger_out,
    output logic                          result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic [T_WIDTH-1:0]            result_tof_out,
    output logic                          result_hit_out,
    output logic                          sweep_done_out
);

    localparam int                  SC_WIDTH     = cnt_width(SAMPLE_CYCLES);
    localparam logic [T_WIDTH-1:0]  T_ONE        = T_WIDTH'(32'sd1);
    localparam logic [T_WIDTH-1:0]  T_BURST_LAST = T_WIDTH'(BURST_CYCLES - 32'sd1);
    localparam logic [T_WIDTH-1:0]  T_PING_LAST  = T_WIDTH'(PERIOD_CYCLES - 32'sd1);
    localparam logic [T_WIDTH-1:0]  T_ECHO_OPEN  = T_WIDTH'(BURST_CYCLES + BLANK_CYCLES);
    localparam logic [SC_WIDTH-1:0] SC_ONE       = SC_WIDTH'(32'sd1);
    localparam logic [SC_WIDTH-1:0] SC_LAST      = SC_WIDTH'(SAMPLE_CYCLES - 32'sd1);

    if (BURST_CYCLES + BLANK_CYCLES >= PERIOD_CYCLES) begin : g_bad_timing
        $error("BURST_CYCLES + BLANK_CYCLES must be below PERIOD_CYCLES");
    end
    if (ANGLE_MIN > ANGLE_MAX) begin : g_bad_range
        $error("ANGLE_MIN must not exceed ANGLE_MAX");
    end
    if (ANGLE_STEP < 32'sd1 || SAMPLE_CYCLES < 32'sd1 || BURST_CYCLES < 32'sd1) begin : g_bad_step
        $error("ANGLE_STEP, SAMPLE_CYCLES and BURST_CYCLES must be positive");
    end

    ping_state_e                   state_r, state_next_s;
    logic [T_WIDTH-1:0]            t_r, t_next_s;
    logic [SC_WIDTH-1:0]           sc_r, sc_next_s;
    logic                          sweep_latched_r, sweep_latched_next_s;
    logic                          hit_r, hit_next_s;
    logic [T_WIDTH-1:0]            tof_r, tof_next_s;
    logic                          ping_start_s, ping_end_s, echo_s, advance_s;
    logic signed [ANGLE_WIDTH-1:0] start_angle_s;
    logic                          seq_done_s;

    logic signed [ANGLE_WIDTH-1:0] beam_angle_r, beam_angle_next_s;
    logic                          burst_active_r, burst_active_next_s;
    logic                          burst_start_r;
    logic                          sample_trigger_r, sample_trigger_next_s;
    logic                          result_valid_r;
    logic signed [ANGLE_WIDTH-1:0] result_angle_r, result_angle_next_s;
    logic [T_WIDTH-1:0]            result_tof_r, result_tof_next_s;
    logic                          result_hit_r, result_hit_next_s;
    logic                          sweep_done_r;

    assign echo_s = (state_r == LISTEN) && (t_r >= T_ECHO_OPEN) && sample_valid_in
                    && (sample_in > threshold_in) && !hit_r;
    assign advance_s = ping_end_s && sweep_latched_r;

    angle_sequencer #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .ANGLE_MIN   (ANGLE_MIN),
        .ANGLE_MAX   (ANGLE_MAX),
        .ANGLE_STEP  (ANGLE_STEP)
    ) u_angle_sequencer (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .advance_in      (advance_s),
        .sweep_mode_in   (sweep_mode_in),
        .fixed_angle_in  (fixed_angle_in),
        .start_angle_out (start_angle_s),
        .sweep_done_out  (seq_done_s)
    );

    // Ping FSM next state and ping time counter.
    always_comb begin
        state_next_s = state_r;
        t_next_s     = t_r;
        ping_start_s = 1'b0;
        ping_end_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable_in) begin
                    state_next_s = BURST;
                    t_next_s     = '0;
                    ping_start_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BURST: begin
                t_next_s = t_r + T_ONE;
                if (t_r == T_BURST_LAST) begin
                    state_next_s = LISTEN;
                end else begin
                    state_next_s = BURST;
                end
            end
            LISTEN: begin
                if (t_r == T_PING_LAST) begin
                    // Back-to-back pings keep the period exactly PERIOD_CYCLES.
                    ping_end_s = 1'b1;
                    if (enable_in) begin
                        state_next_s = BURST;
                        t_next_s     = '0;
                        ping_start_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    t_next_s = t_r + T_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                t_next_s     = '0;
            end
        endcase
    end

    // Trigger wrap counter, echo capture, angle latch and next registered outputs.
    always_comb begin
        if ((state_r == LISTEN) && (state_next_s == LISTEN)) begin
            if (sc_r == SC_LAST) begin
                sc_next_s = '0;
            end else begin
                sc_next_s = sc_r + SC_ONE;
            end
        end else begin
            sc_next_s = '0;
        end
        burst_active_next_s   = (state_next_s == BURST);
        sample_trigger_next_s = (state_next_s == LISTEN) && (sc_next_s == '0);

        if (ping_start_s) begin
            hit_next_s           = 1'b0;
            tof_next_s           = '0;
            beam_angle_next_s    = start_angle_s;
            sweep_latched_next_s = sweep_mode_in;
        end else if (echo_s) begin
            hit_next_s           = 1'b1;
            tof_next_s           = t_r;
            beam_angle_next_s    = beam_angle_r;
            sweep_latched_next_s = sweep_latched_r;
        end else begin
            hit_next_s           = hit_r;
            tof_next_s           = tof_r;
            beam_angle_next_s    = beam_angle_r;
            sweep_latched_next_s = sweep_latched_r;
        end

        // An echo on the final listen cycle still lands in this ping's result.
        if (ping_end_s) begin
            result_angle_next_s = beam_angle_r;
            result_hit_next_s   = hit_r || echo_s;
            result_tof_next_s   = echo_s ? t_r : tof_r;
        end else begin
            result_angle_next_s = result_angle_r;
            result_hit_next_s   = result_hit_r;
            result_tof_next_s   = result_tof_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r          <= IDLE;
            t_r              <= '0;
            sc_r             <= '0;
            sweep_latched_r  <= 1'b0;
            hit_r            <= 1'b0;
            tof_r            <= '0;
            beam_angle_r     <= '0;
            burst_active_r   <= 1'b0;
            burst_start_r    <= 1'b0;
            sample_trigger_r <= 1'b0;
            result_valid_r   <= 1'b0;
            result_angle_r   <= '0;
            result_tof_r     <= '0;
            result_hit_r     <= 1'b0;
            sweep_done_r     <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            t_r              <= t_next_s;
            sc_r             <= sc_next_s;
            sweep_latched_r  <= sweep_latched_next_s;
            hit_r            <= hit_next_s;
            tof_r            <= tof_next_s;
            beam_angle_r     <= beam_angle_next_s;
            burst_active_r   <= burst_active_next_s;
            burst_start_r    <= ping_start_s;
            sample_trigger_r <= sample_trigger_next_s;
            result_valid_r   <= ping_end_s;
            result_angle_r   <= result_angle_next_s;
            result_tof_r     <= result_tof_next_s;
            result_hit_r     <= result_hit_next_s;
            sweep_done_r     <= seq_done_s;
        end
    end

    assign beam_angle_out     = beam_angle_r;
    assign burst_active_out   = burst_active_r;
    assign burst_start_out    = burst_start_r;
    assign sample_trigger_out = sample_trigger_r;
    assign result_valid_out   = result_valid_r;
    assign result_angle_out   = result_angle_r;
    assign result_tof_out     = result_tof_r;
    assign result_hit_out     = result_hit_r;
    assign sweep_done_out     = sweep_done_r;

endmodule
